// File: rtl/mg_card_press_checker_pkg.sv
// rtl/mg_card_press_checker_pkg.sv - grid geometry, card state codes and FSM states for the card press checker
package mg_cards_pkg;

  localparam int GRID_X0 = 64;
  localparam int GRID_Y0 = 64;
  localparam int CARD_W  = 200;
  localparam int CARD_H  = 200;
  localparam int PITCH_X = 240;
  localparam int PITCH_Y = 224;
  localparam int COLS    = 4;
  localparam int ROWS    = 3;
  localparam int NUM_CARDS = COLS * ROWS;

  localparam int READ_LATENCY   = 1;
  localparam int LOCKOUT_CYCLES = 16;

  localparam logic [1:0] ST_HIDDEN  = 2'b00;
  localparam logic [1:0] ST_SHOWN   = 2'b01;
  localparam logic [1:0] ST_MATCHED = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2
  } press_state_t;

endpackage

// File: rtl/mg_card_press_checker_if.sv
// rtl/mg_card_press_checker_if.sv - mouse, regfile and game-FSM signals of the card press checker
interface mg_card_press_if;
  logic        enable;
  logic        kind_of_event;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [1:0]  card_test_state;
  logic [3:0]  card_to_test_address;
  logic [3:0]  card_clicked_address;
  logic        event_occurred;

  modport master (
    output enable, kind_of_event, mouse_xpos, mouse_ypos, card_test_state,
    input  card_to_test_address, card_clicked_address, event_occurred
  );

  modport slave (
    input  enable, kind_of_event, mouse_xpos, mouse_ypos, card_test_state,
    output card_to_test_address, card_clicked_address, event_occurred
  );
endinterface

// File: rtl/mg_card_press_checker_hit_decoder.sv
// rtl/mg_card_press_checker_hit_decoder.sv - combinational cursor position to card index decoder
module mg_card_hit_decoder
  import mg_cards_pkg::*;
(
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  output logic        o_hit,
  output logic [3:0]  o_index
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic signed [12:0] w_dx;
  logic signed [12:0] w_dy;
  logic               w_col_ok;
  logic               w_row_ok;
  logic [COL_W-1:0]   w_col;
  logic [ROW_W-1:0]   w_row;

  assign w_dx = $signed({1'b0, i_x}) - 13'(GRID_X0);
  assign w_dy = $signed({1'b0, i_y}) - 13'(GRID_Y0);

  // Each column/row is a [start, start+size) window; negative offsets never match
  always_comb begin
    w_col_ok = 1'b0;
    w_col    = '0;
    for (int c = 0; c < COLS; c++) begin
      if (w_dx >= 13'(c * PITCH_X) && w_dx < 13'(c * PITCH_X + CARD_W)) begin
        w_col_ok = 1'b1;
        w_col    = COL_W'(c);
      end
    end
  end

  always_comb begin
    w_row_ok = 1'b0;
    w_row    = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (w_dy >= 13'(r * PITCH_Y) && w_dy < 13'(r * PITCH_Y + CARD_H)) begin
        w_row_ok = 1'b1;
        w_row    = ROW_W'(r);
      end
    end
  end

  assign o_hit   = w_col_ok & w_row_ok;
  assign o_index = 4'(w_row * COLS) + 4'(w_col);

endmodule

// File: rtl/mg_card_press_checker.sv
// rtl/mg_card_press_checker.sv - click edge detect, card state check FSM and press outputs
// Optional post-press lockout window enabled by defining CARD_PRESS_LOCKOUT_EN.
module mg_card_press_checker
  import mg_cards_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  mg_card_press_if.slave  bus
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  press_state_t     r_state;
  press_state_t     w_next;
  logic             r_btn_prev;
  logic [LAT_W-1:0] r_wait_cnt;
  logic [3:0]       r_to_test_addr;
  logic [3:0]       r_clicked_addr;
  logic             r_event;

  logic             w_hit;
  logic [3:0]       w_index;
  logic             w_lock_free;
  logic             w_accept;
  logic             w_load;
  logic             w_fire;
  logic             w_wait_done;

  mg_card_hit_decoder u_hit_decoder (
    .i_x     (bus.mouse_xpos),
    .i_y     (bus.mouse_ypos),
    .o_hit   (w_hit),
    .o_index (w_index)
  );

  // Button level is tracked even while disabled so a held button never counts as a fresh click
  always_ff @(posedge i_clk) begin
    if (i_rst) r_btn_prev <= 1'b0;
    else       r_btn_prev <= bus.kind_of_event;
  end

  assign w_accept    = bus.enable & bus.kind_of_event & ~r_btn_prev & w_lock_free & w_hit;
  assign w_wait_done = (r_wait_cnt == LAT_W'(READ_LATENCY - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = WAIT;
      WAIT:    if (!bus.enable) w_next = IDLE;
               else if (w_wait_done) w_next = CHECK;
      CHECK:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_fire = 1'b0;
    case (r_state)
      IDLE:    w_load = w_accept;
      CHECK:   w_fire = bus.enable & (bus.card_test_state == ST_HIDDEN);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != WAIT) r_wait_cnt <= '0;
    else                          r_wait_cnt <= r_wait_cnt + LAT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_test_addr <= 4'd0;
      r_clicked_addr <= 4'd0;
      r_event        <= 1'b0;
    end else begin
      if (w_load) r_to_test_addr <= w_index;
      if (w_fire) r_clicked_addr <= r_to_test_addr;
      r_event <= w_fire;
    end
  end

`ifdef CARD_PRESS_LOCKOUT_EN
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  logic [LOCK_W-1:0] r_lock_cnt;

  // Only reset clears the window; dropping enable leaves it running
  always_ff @(posedge i_clk) begin
    if (i_rst)                 r_lock_cnt <= '0;
    else if (w_fire)           r_lock_cnt <= LOCK_W'(LOCKOUT_CYCLES);
    else if (r_lock_cnt != '0) r_lock_cnt <= r_lock_cnt - LOCK_W'(1);
  end

  assign w_lock_free = (r_lock_cnt == '0);
`else
  assign w_lock_free = 1'b1;
`endif

  assign bus.card_to_test_address = r_to_test_addr;
  assign bus.card_clicked_address = r_clicked_addr;
  assign bus.event_occurred       = r_event;

endmodule

// File: tb/tb_mg_card_press_checker.sv
// tb/tb_mg_card_press_checker.sv - scoreboard bench for mg_card_press_checker with a geometric reference model
module tb_mg_card_press_checker;
  import mg_cards_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mg_card_press_if bus ();

  mg_card_press_checker dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    int idx;
    int at;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         exp_addr = 0;
  int         exp_clicked = 0;
  int         last_pulse = -1000;
  logic [1:0] card_state [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Regfile stand-in with one cycle of read latency
  always @(posedge clk) bus.card_test_state <= card_state[bus.card_to_test_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.event_occurred === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d addr %0d, required none", cyc, bus.card_clicked_address);
      end else begin
        e = sb.pop_front();
        chk("pulse_index", 32'(bus.card_clicked_address), e.idx);
        chk("pulse_cycle", cyc, e.at);
      end
    end
  end

  function automatic bit model_hit(input int x, input int y, output int idx);
    int col, row;
    idx = 0;
    if (x < GRID_X0 || y < GRID_Y0) return 1'b0;
    col = (x - GRID_X0) / PITCH_X;
    row = (y - GRID_Y0) / PITCH_Y;
    if (col >= COLS || row >= ROWS) return 1'b0;
    if ((x - GRID_X0) % PITCH_X >= CARD_W || (y - GRID_Y0) % PITCH_Y >= CARD_H) return 1'b0;
    idx = row * COLS + col;
    return 1'b1;
  endfunction

  function automatic bit lock_ok(input int c);
`ifdef CARD_PRESS_LOCKOUT_EN
    return (c - last_pulse) >= LOCKOUT_CYCLES;
`else
    return 1'b1;
`endif
  endfunction

  task automatic press(input int x, input int y, input int hold, input bit en, input int gap);
    int c, idx;
    bit hit;
    @(negedge clk);
    bus.enable        = en;
    bus.mouse_xpos    = 12'(x);
    bus.mouse_ypos    = 12'(y);
    bus.kind_of_event = 1'b1;
    c   = cyc;
    hit = model_hit(x, y, idx);
    if (en && hit && lock_ok(c)) begin
      exp_addr = idx;
      if (card_state[idx] == ST_HIDDEN) begin
        sb.push_back('{idx: idx, at: c + 3});
        exp_clicked = idx;
        last_pulse  = c + 3;
      end
    end
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    bus.kind_of_event = 1'b0;
    repeat (gap) @(negedge clk);
    chk("test_addr", 32'(bus.card_to_test_address), exp_addr);
    chk("clicked_addr", 32'(bus.card_clicked_address), exp_clicked);
  endtask

  initial begin
    int x, y, col, row;
    bus.enable        = 1'b0;
    bus.kind_of_event = 1'b0;
    bus.mouse_xpos    = '0;
    bus.mouse_ypos    = '0;
    for (int i = 0; i < 16; i++) card_state[i] = ST_HIDDEN;

    repeat (3) @(negedge clk);
    chk("rst_test_addr", 32'(bus.card_to_test_address), 0);
    chk("rst_clicked_addr", 32'(bus.card_clicked_address), 0);
    chk("rst_event", 32'(bus.event_occurred), 0);
    rst = 1'b0;

    press(100, 100, 1, 1'b1, 20);
    press(420, 330, 3, 1'b1, 20);
    press(983, 711, 1, 1'b1, 20);
    card_state[5] = ST_SHOWN;
    press(420, 330, 1, 1'b1, 20);
    card_state[5] = ST_MATCHED;
    press(420, 330, 1, 1'b1, 20);
    card_state[5] = ST_HIDDEN;

    press(280, 100, 1, 1'b1, 20);
    press(1000, 750, 1, 1'b1, 20);
    press(100, 100, 1, 1'b0, 20);
    press(64, 64, 1, 1'b1, 20);
    press(983, 711, 1, 1'b1, 20);
    press(263, 263, 1, 1'b1, 20);
    press(264, 100, 1, 1'b1, 20);
    press(983, 711, 1, 1'b1, 20);

    // enable drops in the WAIT cycle: address already loaded, no pulse
    @(negedge clk);
    bus.enable = 1'b1; bus.mouse_xpos = 12'd100; bus.mouse_ypos = 12'd100; bus.kind_of_event = 1'b1;
    exp_addr = 0;
    @(negedge clk);
    bus.enable = 1'b0; bus.kind_of_event = 1'b0;
    repeat (6) @(negedge clk);
    chk("drop_test_addr", 32'(bus.card_to_test_address), exp_addr);
    chk("drop_clicked_addr", 32'(bus.card_clicked_address), exp_clicked);

    // enable rises with the button already held: no click
    @(negedge clk);
    bus.mouse_xpos = 12'd420; bus.mouse_ypos = 12'd330; bus.kind_of_event = 1'b1;
    @(negedge clk);
    bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    bus.kind_of_event = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_test_addr", 32'(bus.card_to_test_address), exp_addr);
    chk("held_clicked_addr", 32'(bus.card_clicked_address), exp_clicked);

    // second click 5 cycles after a pulse, then 20 cycles after a pulse
    press(100, 100, 1, 1'b1, 6);
    press(420, 330, 1, 1'b1, 20);
    press(100, 100, 1, 1'b1, 21);
    press(420, 330, 1, 1'b1, 20);

    // reset in the WAIT cycle
    @(negedge clk);
    bus.enable = 1'b1; bus.mouse_xpos = 12'd983; bus.mouse_ypos = 12'd711; bus.kind_of_event = 1'b1;
    @(negedge clk);
    rst = 1'b1; bus.kind_of_event = 1'b0;
    @(negedge clk);
    chk("midrst_test_addr", 32'(bus.card_to_test_address), 0);
    chk("midrst_clicked_addr", 32'(bus.card_clicked_address), 0);
    chk("midrst_event", 32'(bus.event_occurred), 0);
    rst = 1'b0;
    exp_addr = 0; exp_clicked = 0; last_pulse = -1000;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NUM_CARDS; i++) card_state[i] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        x = $urandom_range(0, 1100);
        y = $urandom_range(0, 800);
      end else begin
        col = $urandom_range(0, COLS - 1);
        row = $urandom_range(0, ROWS - 1);
        x = GRID_X0 + col * PITCH_X + $urandom_range(0, PITCH_X - 1);
        y = GRID_Y0 + row * PITCH_Y + $urandom_range(0, PITCH_Y - 1);
      end
      press(x, y, $urandom_range(1, 4), ($urandom_range(0, 7) != 0), 20);
    end

    repeat (10) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
